// File: rtl/instr_mem_if.sv
// Fetch-side read port plus loader write port
// between the fetch stage and instr_mem_responder.
interface instr_mem_if;
  logic        REQ_CPU;
  logic [15:0] RADDR_CPU;
  logic [15:0] DATA_OUT;
  logic        ACK_CPU;
  logic        ERR;
  logic        BUSY;
  logic        WE_CPU;
  logic [15:0] WADDR_CPU;
  logic [15:0] WDATA_CPU;

  modport master (
    output REQ_CPU, RADDR_CPU,
    output WE_CPU, WADDR_CPU, WDATA_CPU,
    input  DATA_OUT, ACK_CPU, ERR, BUSY
  );

  modport slave (
    input  REQ_CPU, RADDR_CPU,
    input  WE_CPU, WADDR_CPU, WDATA_CPU,
    output DATA_OUT, ACK_CPU, ERR, BUSY
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: wait-stated word reads
// with one-cycle ack, plus an independent write port.
module instr_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  instr_mem_if.slave bus
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        err_q, err_d;

  logic [15:0] mem [DEPTH];
  logic [15:0] rd_addr;
  logic        rd_en;
  logic        rd_ok;

  function automatic logic in_range(
    input logic [15:0] a
  );
    return (a >> ADDR_W) == 16'h0000;
  endfunction

  // WAIT_STATES=0 goes straight from IDLE to RESP,
  // so the live request address feeds the read.
  assign rd_addr = (state_q == S_IDLE) ?
                   bus.RADDR_CPU : addr_q;
  assign rd_ok   = in_range(rd_addr);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.REQ_CPU) begin
          addr_d = bus.RADDR_CPU;
          if (WS == 4'd0) begin
            state_d = S_RESP;
            rd_en   = 1'b1;
          end else begin
            cnt_d   = WS;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          rd_en   = 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Data is sampled from the array before this edge's
  // write lands, so a same-edge write returns old data.
  always_comb begin
    data_d = data_q;
    err_d  = 1'b0;
    if (rd_en) begin
      err_d  = !rd_ok;
      data_d = rd_ok ? mem[rd_addr[ADDR_W-1:0]]
                     : 16'h0000;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && bus.WE_CPU &&
        in_range(bus.WADDR_CPU)) begin
      mem[bus.WADDR_CPU[ADDR_W-1:0]] <= bus.WDATA_CPU;
    end
  end

  assign bus.ACK_CPU  = (state_q == S_RESP);
  assign bus.BUSY     = (state_q != S_IDLE);
  assign bus.ERR      = err_q;
  assign bus.DATA_OUT = data_q;

endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Memory-side responder for the pipeline's instruction-fetch read port. It accepts word read requests from the fetch stage, waits a fixed number of configurable wait states, and returns the 16-bit word with a one-cycle acknowledge. An independent single-cycle write port lets the loader or memory stage fill and modify the backing array. It sits between the fetch stage and the on-chip word-addressed RAM.

## Interface
- ADDR_W, default 8: implemented address bits; the array holds 2^ADDR_W words of 16 bits.
- WAIT_STATES, default 1, range 0..15: extra cycles between request acceptance and acknowledge.
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  reset, asynchronous, active-high.
- REQ_CPU  in  1  read request; sampled only in IDLE.
- RADDR_CPU  in  16  word read address; sampled with REQ_CPU.
- DATA_OUT  out  16  read data; valid while ACK_CPU=1, held until the next acknowledge.
- ACK_CPU  out  1  one-cycle pulse marking read completion.
- ERR  out  1  out-of-range flag; meaningful only while ACK_CPU=1.
- BUSY  out  1  high while a read is in flight (WAIT or RESP).
- WE_CPU  in  1  write enable; accepted in any state.
- WADDR_CPU  in  16  word write address.
- WDATA_CPU  in  16  write data.

## Operation
- States: IDLE, WAIT, RESP. A 4-bit wait counter and a 16-bit latched read address are registered.
- IDLE: if REQ_CPU=1, latch RADDR_CPU. Go to RESP if WAIT_STATES=0; otherwise load the counter with WAIT_STATES and go to WAIT. If REQ_CPU=0, stay in IDLE.
- WAIT: decrement the counter each cycle. On the edge where the counter reaches 0, go to RESP. REQ_CPU is ignored.
- RESP: ACK_CPU=1 for exactly one cycle, then IDLE unconditionally. A REQ_CPU held during RESP is not accepted until the following IDLE cycle.
- DATA_OUT and ERR are registered on the edge that enters RESP.
- Range check: an address is out of range when any of bits [15:ADDR_W] is 1.
  - In-range read: DATA_OUT = mem[addr[ADDR_W-1:0]], ERR=0.
  - Out-of-range read: DATA_OUT = 16'h0000, ERR=1.
- Write: when WE_CPU=1 and WADDR_CPU is in range, mem[WADDR_CPU[ADDR_W-1:0]] <= WDATA_CPU at the posedge.
  - Writes complete in one cycle and never stall or alter the FSM.
  - Out-of-range writes are silently dropped.
- Read/write ordering, same address:
  - A write committed at an edge strictly before the RESP-entry edge is visible to the in-flight read.
  - A write on the RESP-entry edge itself is not visible (old data returned); it is visible to later reads.
- ERR and ACK_CPU are 0 outside RESP. DATA_OUT holds its last acknowledged value.
- Array contents are not cleared by reset and are undefined until written.

## Timing
- Reset values, asynchronous: state=IDLE, counter=0, ACK_CPU=0, ERR=0, BUSY=0, DATA_OUT=16'h0000.
- Reset asserted mid-read aborts the read; no ACK is ever issued for it.
- A write with WE_CPU=1 on an edge while RST=1 is dropped.
- Latency: request sampled at edge T → ACK_CPU high during the cycle after edge T+WAIT_STATES, low after edge T+WAIT_STATES+1.
- BUSY is high from edge T to edge T+WAIT_STATES+1, and is 0 during the IDLE cycle in which a request is sampled.
- Maximum throughput: one read per WAIT_STATES+2 cycles (IDLE sample + WAIT_STATES + RESP).
  - WAIT_STATES=0: one read per 2 cycles.
- ACK_CPU never asserts in two consecutive cycles.

## Test plan
- Reset and idle: assert RST mid-cycle without a clock edge → all outputs go to 0 immediately. Release RST and hold REQ_CPU=0 for 10 cycles → ACK_CPU=0 and BUSY=0 throughout.
- Basic read, WAIT_STATES=1: write 16'hBEEF to address 16'h0005, then request 16'h0005 at edge T → ACK_CPU and DATA_OUT=16'hBEEF in the cycle after edge T+1. ERR=0, and BUSY is high for 2 cycles.
- Back-to-back reads: REQ_CPU held high over addresses 3 and 4 holding 16'h1111 and 16'h2222 → ACK pulses separated by exactly WAIT_STATES+2 cycles, returning 16'h1111 then 16'h2222. Repeat with WAIT_STATES=0 → one ACK every 2 cycles.
- Out of range, ADDR_W=8: read 16'h0100 → ACK with ERR=1 and DATA_OUT=16'h0000. Write 16'hFFFF to 16'h0100, then read 16'h0000 → original contents unchanged.
- Write collision, WAIT_STATES=2, mem[7]=16'hAAAA:
  - Write 16'h5555 to address 7 one edge before RESP entry → 16'h5555 returned.
  - Repeat with the write on the RESP-entry edge → 16'hAAAA returned; the next read of 7 returns 16'h5555.
- Reset mid-read: request at edge T with WAIT_STATES=3, pulse RST during WAIT → no ACK, state IDLE. A new request is then accepted and acknowledged after the normal latency.
